// File: rtl/gpc_pkg.sv
// Shared constants and state encoding for the GPC32 instruction-memory responder.
// Pure declarations: no logic, no latency, no flow control.
package gpc_pkg;

   localparam int          INST_MAX   = 32;
   localparam int          WIDTH      = 32;
   localparam int          DEPTH_LOG2 = 10;
   localparam logic [31:0] PC_START   = 32'h8000_0000;
   localparam logic [31:0] FAULT_INST = 32'h0010_0073;

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/imem_ram.sv
// Simple dual-port word RAM: one synchronous write port and one synchronous read port.
// Read data appears the cycle after re and holds until the next read; no backpressure.
module imem_ram #(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] rdata_q;

   // Storage is deliberately unreset so the image survives a core reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata_q <= mem[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: loads an image over load_*, then serves pc fetches.
// Fetch latency 1 cycle; a 1-entry output hold stalls pc_ready while inst is unconsumed.
module imem_responder #(
   parameter int                  INST_MAX   = gpc_pkg::INST_MAX,
   parameter int                  WIDTH      = gpc_pkg::WIDTH,
   parameter logic [WIDTH-1:0]    PC_START   = WIDTH'(gpc_pkg::PC_START),
   parameter int                  DEPTH_LOG2 = gpc_pkg::DEPTH_LOG2,
   parameter logic [INST_MAX-1:0] FAULT_INST = INST_MAX'(gpc_pkg::FAULT_INST)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_valid,
   input  logic [INST_MAX-1:0] load_data,
   input  logic                load_last,
   output logic                load_ready,
   output logic                loaded,
   input  logic                pc_valid,
   input  logic [WIDTH-1:0]    pc,
   output logic                pc_ready,
   output logic                inst_valid,
   output logic [INST_MAX-1:0] inst,
   output logic                inst_fault,
   input  logic                inst_ready
);

   import gpc_pkg::*;

   localparam int               DEPTH = 2**DEPTH_LOG2;
   localparam logic [WIDTH-1:0] SPAN  = WIDTH'(DEPTH * 4);

   state_t                state_q, state_d;
   logic [DEPTH_LOG2-1:0] load_ptr_q, load_ptr_d;
   logic                  inst_valid_q, inst_valid_d;
   logic                  fault_q, fault_d;
   logic                  from_ram_q, from_ram_d;

   logic [WIDTH-1:0]      off;
   logic                  addr_fault;
   logic                  load_fire;
   logic                  accept;
   logic [INST_MAX-1:0]   ram_rdata;

   assign off        = pc - PC_START;
   assign addr_fault = (pc < PC_START) || (off >= SPAN) || (pc[1:0] != 2'b00);

   always_comb begin
      state_d      = state_q;
      load_ptr_d   = load_ptr_q;
      inst_valid_d = inst_valid_q;
      fault_d      = fault_q;
      from_ram_d   = from_ram_q;

      load_ready = (state_q == ST_LOAD);
      loaded     = (state_q == ST_RUN);
      pc_ready   = (state_q == ST_RUN) && (!inst_valid_q || inst_ready);
      load_fire  = load_ready && load_valid;
      accept     = pc_valid && pc_ready;

      // A full-depth image ends the load even without load_last, so the pointer never wraps a write.
      if (load_fire) begin
         load_ptr_d = load_ptr_q + 1'b1;
         if (load_last || (&load_ptr_q)) state_d = ST_RUN;
      end

      if (accept) begin
         inst_valid_d = 1'b1;
         fault_d      = addr_fault;
         from_ram_d   = !addr_fault;
      end else if (inst_ready) begin
         inst_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_LOAD;
         load_ptr_q   <= '0;
         inst_valid_q <= 1'b0;
         fault_q      <= 1'b0;
         from_ram_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         load_ptr_q   <= load_ptr_d;
         inst_valid_q <= inst_valid_d;
         fault_q      <= fault_d;
         from_ram_q   <= from_ram_d;
      end
   end

   // The RAM read register doubles as the data half of the hold buffer: it only reloads on accept.
   imem_ram #(
      .AW (DEPTH_LOG2),
      .DW (INST_MAX)
   ) u_ram (
      .clk   (clk),
      .we    (load_fire),
      .waddr (load_ptr_q),
      .wdata (load_data),
      .re    (accept && !addr_fault),
      .raddr (off[DEPTH_LOG2+1:2]),
      .rdata (ram_rdata)
   );

   assign inst_valid = inst_valid_q;
   assign inst_fault = fault_q;
   assign inst       = fault_q ? FAULT_INST : (from_ram_q ? ram_rdata : '0);

endmodule
